// File: rtl/cam_request_master.sv
// cam_request_master
//
// Initiator-side sequencer for a 32-entry x 32-bit CAM. Commands (read,
// write, search) arrive on a valid/ready port and are buffered in a small
// FIFO. They are issued one at a time on the CAM request pins. After a fixed
// response latency the CAM result is captured and returned on a valid/ready
// response port, in strict command order.
//
// Parameters:
//   CMD_DEPTH  command FIFO entries (power of two, >= 2)
//   RESP_LAT   cycles from the CAM enable cycle to valid CAM outputs (>= 1)
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   cmd_valid_i/cmd_ready_o      command handshake
//   cmd_op_i/index_i/data_i      00 read, 01 write, 10 search, 11 reserved
//   rsp_valid_o/rsp_ready_i      response handshake
//   rsp_op/hit/index/data_o      captured response fields
//   busy_o                       FSM not idle or FIFO not empty
//   read/write/search_enable_o   one-cycle CAM strobes
//   read/write_index_o, write/search_data_o   CAM request fields
//   read_valid_i, read_value_i, search_valid_i, search_index_i  CAM results
//
// Optional feature (macro CAM_REQ_STATS_EN):
//   search_hit_cnt_o, search_miss_cnt_o  saturating 16-bit search counters

module cam_request_master #(
    parameter int CMD_DEPTH = 4,
    parameter int RESP_LAT  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [4:0]  cmd_index_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [1:0]  rsp_op_o,
    output logic        rsp_hit_o,
    output logic [4:0]  rsp_index_o,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        read_enable_o,
    output logic        write_enable_o,
    output logic        search_enable_o,
    output logic [4:0]  read_index_o,
    output logic [4:0]  write_index_o,
    output logic [31:0] write_data_o,
    output logic [31:0] search_data_o,
    input  logic        read_valid_i,
    input  logic        search_valid_i,
    input  logic [31:0] read_value_i,
    input  logic [4:0]  search_index_i
`ifdef CAM_REQ_STATS_EN
    ,
    output logic [15:0] search_hit_cnt_o,
    output logic [15:0] search_miss_cnt_o
`endif
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state, state_next;

    logic [1:0]    op_mem   [CMD_DEPTH];
    logic [4:0]    idx_mem  [CMD_DEPTH];
    logic [31:0]   data_mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [LW-1:0] lat_cnt;

    logic        push, pop, lat_last;
    logic [1:0]  head_op;
    logic [4:0]  head_idx;
    logic [31:0] head_data;

    // Ready depends only on the registered count, so a full FIFO never
    // accepts even when a pop happens in the same cycle.
    assign cmd_ready_o = (count != CW'(CMD_DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state == ST_RESP) && rsp_ready_i;
    assign head_op     = op_mem[rd_ptr];
    assign head_idx    = idx_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign lat_last    = (lat_cnt == LW'(RESP_LAT - 1));
    assign busy_o      = (state != ST_IDLE) || (count != '0);

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            op_mem[wr_ptr]   <= cmd_op_i;
            idx_mem[wr_ptr]  <= cmd_index_i;
            data_mem[wr_ptr] <= cmd_data_i;
        end
    end

    // The head entry stays in the FIFO until its response is consumed, so
    // the issued command's fields remain available through WAIT and RESP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Strobes and request fields are decoded from state, so an asynchronous
    // reset drops them in the same instant.
    always_comb begin
        state_next      = state;
        read_enable_o   = 1'b0;
        write_enable_o  = 1'b0;
        search_enable_o = 1'b0;
        read_index_o    = '0;
        write_index_o   = '0;
        write_data_o    = '0;
        search_data_o   = '0;
        rsp_valid_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                case (head_op)
                    2'b00: begin
                        read_enable_o = 1'b1;
                        read_index_o  = head_idx;
                        state_next    = ST_WAIT;
                    end
                    2'b01: begin
                        write_enable_o = 1'b1;
                        write_index_o  = head_idx;
                        write_data_o   = head_data;
                        state_next     = ST_RESP;
                    end
                    2'b10: begin
                        search_enable_o = 1'b1;
                        search_data_o   = head_data;
                        state_next      = ST_WAIT;
                    end
                    default: state_next = ST_RESP;
                endcase
            end
            ST_WAIT: begin
                if (lat_last) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Response fields: writes and reserved ops are complete at issue time;
    // reads and searches are captured on the last latency cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat_cnt     <= '0;
            rsp_op_o    <= '0;
            rsp_hit_o   <= 1'b0;
            rsp_index_o <= '0;
            rsp_data_o  <= '0;
        end else if (state == ST_ISSUE) begin
            lat_cnt  <= '0;
            rsp_op_o <= head_op;
            if (head_op == 2'b01) begin
                rsp_hit_o   <= 1'b1;
                rsp_index_o <= head_idx;
                rsp_data_o  <= head_data;
            end else if (head_op == 2'b11) begin
                rsp_hit_o   <= 1'b0;
                rsp_index_o <= '0;
                rsp_data_o  <= '0;
            end
        end else if (state == ST_WAIT) begin
            lat_cnt <= lat_cnt + LW'(1);
            if (lat_last) begin
                if (head_op == 2'b00) begin
                    rsp_hit_o   <= read_valid_i;
                    rsp_index_o <= head_idx;
                    rsp_data_o  <= read_value_i;
                end else begin
                    rsp_hit_o   <= search_valid_i;
                    rsp_index_o <= search_index_i;
                    rsp_data_o  <= head_data;
                end
            end
        end
    end

`ifdef CAM_REQ_STATS_EN
    // Search statistics, saturating at 0xFFFF.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            search_hit_cnt_o  <= '0;
            search_miss_cnt_o <= '0;
        end else if (state == ST_WAIT && lat_last && head_op == 2'b10) begin
            if (search_valid_i) begin
                if (search_hit_cnt_o != 16'hFFFF)
                    search_hit_cnt_o <= search_hit_cnt_o + 16'd1;
            end else begin
                if (search_miss_cnt_o != 16'hFFFF)
                    search_miss_cnt_o <= search_miss_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_request_master.sv
// tb_cam_request_master
//
// Directed bench for cam_request_master (CMD_DEPTH=4, RESP_LAT=1) with a
// small behavioural CAM stub. Inputs change and outputs are sampled on the
// falling clock edge. Cycle "N" is the cycle whose rising edge accepts a
// command.

module tb_cam_request_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [4:0]  cmd_index_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_op_o;
    logic        rsp_hit_o;
    logic [4:0]  rsp_index_o;
    logic [31:0] rsp_data_o;
    logic        busy_o;
    logic        read_enable_o, write_enable_o, search_enable_o;
    logic [4:0]  read_index_o, write_index_o;
    logic [31:0] write_data_o, search_data_o;
    logic        read_valid_i, search_valid_i;
    logic [31:0] read_value_i;
    logic [4:0]  search_index_i;
`ifdef CAM_REQ_STATS_EN
    logic [15:0] search_hit_cnt_o, search_miss_cnt_o;
`endif

    int error_count = 0;
    int check_count = 0;
    int rd_strobes = 0, wr_strobes = 0, sr_strobes = 0;

    always #5 clk_i = ~clk_i;

    cam_request_master #(.CMD_DEPTH(4), .RESP_LAT(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_index_i(cmd_index_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_op_o(rsp_op_o), .rsp_hit_o(rsp_hit_o),
        .rsp_index_o(rsp_index_o), .rsp_data_o(rsp_data_o),
        .busy_o(busy_o),
        .read_enable_o(read_enable_o), .write_enable_o(write_enable_o),
        .search_enable_o(search_enable_o),
        .read_index_o(read_index_o), .write_index_o(write_index_o),
        .write_data_o(write_data_o), .search_data_o(search_data_o),
        .read_valid_i(read_valid_i), .search_valid_i(search_valid_i),
        .read_value_i(read_value_i), .search_index_i(search_index_i)
`ifdef CAM_REQ_STATS_EN
        , .search_hit_cnt_o(search_hit_cnt_o), .search_miss_cnt_o(search_miss_cnt_o)
`endif
    );

    // CAM stub: writes store, reads and searches answer one cycle later.
    logic [31:0] cam_mem   [32];
    logic        cam_valid [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            cam_mem[i]   = '0;
            cam_valid[i] = 1'b0;
        end
        read_valid_i   = 1'b0;
        read_value_i   = '0;
        search_valid_i = 1'b0;
        search_index_i = '0;
    end

    always @(posedge clk_i) begin
        logic       found;
        logic [4:0] where;
        if (write_enable_o) begin
            cam_mem[write_index_o]   <= write_data_o;
            cam_valid[write_index_o] <= 1'b1;
            wr_strobes++;
        end
        if (read_enable_o) begin
            read_valid_i <= cam_valid[read_index_o];
            read_value_i <= cam_mem[read_index_o];
            rd_strobes++;
        end
        if (search_enable_o) begin
            found = 1'b0;
            where = '0;
            for (int i = 0; i < 32; i++) begin
                if (!found && cam_valid[i] && cam_mem[i] == search_data_o) begin
                    found = 1'b1;
                    where = 5'(i);
                end
            end
            search_valid_i <= found;
            search_index_i <= where;
            sr_strobes++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Offers one command starting at a falling edge and returns at the
    // falling edge after it was accepted.
    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] idx,
                                 input logic [31:0] data);
        bit accepted = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_index_i = idx;
        cmd_data_i  = data;
        for (int i = 0; i < 40 && !accepted; i++) begin
            if (cmd_ready_o) accepted = 1;
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        if (!accepted) checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    // Waits (bounded) for a response, checks it, then consumes it.
    task automatic expectRsp(input string tag, input logic [1:0] op, input logic hit,
                             input logic [4:0] idx, input logic [31:0] data);
        int waited = 0;
        while (!rsp_valid_o && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        checkOutput({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        checkOutput({tag, "_op"},    32'(rsp_op_o),    32'(op));
        checkOutput({tag, "_hit"},   32'(rsp_hit_o),   32'(hit));
        checkOutput({tag, "_idx"},   32'(rsp_index_o), 32'(idx));
        checkOutput({tag, "_data"},  rsp_data_o,       data);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        int t_first, t_second, cycle, saw_rsp, s_rd, s_wr, s_sr;
        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = '0;
        cmd_index_i = '0;
        cmd_data_i  = '0;
        rsp_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        checkOutput("rst_ready", 32'(cmd_ready_o), 32'd1);
        checkOutput("rst_busy",  32'(busy_o),      32'd0);
        checkOutput("rst_rspv",  32'(rsp_valid_o), 32'd0);
        checkOutput("rst_strb",  32'({read_enable_o, write_enable_o, search_enable_o}), 32'd0);
        checkOutput("rst_rdata", rsp_data_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Write idx 5 = 0xDEADBEEF with exact cycle timing
        $display("[TB] write timing");
        cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_index_i = 5'd5; cmd_data_i = 32'hDEADBEEF;
        checkOutput("wr_ready_N", 32'(cmd_ready_o), 32'd1);
        @(negedge clk_i);                                  // N+1
        cmd_valid_i = 1'b0;
        checkOutput("wr_busy_N1", 32'(busy_o),         32'd1);
        checkOutput("wr_we_N1",   32'(write_enable_o), 32'd0);
        @(negedge clk_i);                                  // N+2
        checkOutput("wr_we_N2",   32'(write_enable_o), 32'd1);
        checkOutput("wr_widx_N2", 32'(write_index_o),  32'd5);
        checkOutput("wr_wdat_N2", write_data_o,        32'hDEADBEEF);
        checkOutput("wr_rspv_N2", 32'(rsp_valid_o),    32'd0);
        @(negedge clk_i);                                  // N+3
        checkOutput("wr_we_N3",   32'(write_enable_o), 32'd0);
        checkOutput("wr_count",   32'(wr_strobes),     32'd1);
        checkOutput("wr_rspv_N3", 32'(rsp_valid_o),    32'd1);
        expectRsp("wr", 2'b01, 1'b1, 5'd5, 32'hDEADBEEF);
        checkOutput("wr_rspv_done", 32'(rsp_valid_o), 32'd0);

        // Read idx 5 with exact cycle timing
        $display("[TB] read timing");
        cmd_valid_i = 1'b1; cmd_op_i = 2'b00; cmd_index_i = 5'd5; cmd_data_i = '0;
        @(negedge clk_i);                                  // N+1
        cmd_valid_i = 1'b0;
        @(negedge clk_i);                                  // N+2
        checkOutput("rd_re_N2",   32'(read_enable_o), 32'd1);
        checkOutput("rd_ridx_N2", 32'(read_index_o),  32'd5);
        @(negedge clk_i);                                  // N+3
        checkOutput("rd_re_N3",   32'(read_enable_o), 32'd0);
        checkOutput("rd_rspv_N3", 32'(rsp_valid_o),   32'd0);
        @(negedge clk_i);                                  // N+4
        checkOutput("rd_rspv_N4", 32'(rsp_valid_o),   32'd1);
        expectRsp("rd", 2'b00, 1'b1, 5'd5, 32'hDEADBEEF);

        // Two searches: hit then miss, responses in order
        $display("[TB] searches");
        applyStimulus(2'b10, 5'd0, 32'hDEADBEEF);
        applyStimulus(2'b10, 5'd0, 32'h12345678);
        expectRsp("srch_hit",  2'b10, 1'b1, 5'd5, 32'hDEADBEEF);
        expectRsp("srch_miss", 2'b10, 1'b0, 5'd0, 32'h12345678);
`ifdef CAM_REQ_STATS_EN
        checkOutput("stat_hit",  32'(search_hit_cnt_o),  32'd1);
        checkOutput("stat_miss", 32'(search_miss_cnt_o), 32'd1);
`endif

        // Fill the FIFO with rsp_ready low
        $display("[TB] fifo full");
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            cmd_valid_i = 1'b1; cmd_op_i = 2'b01;
            cmd_index_i = 5'(10 + i); cmd_data_i = 32'h100 + 32'(i);
            checkOutput($sformatf("full_ready_%0d", i), 32'(cmd_ready_o), 32'd1);
            @(negedge clk_i);
        end
        checkOutput("full_ready_after4", 32'(cmd_ready_o), 32'd0);
        cmd_op_i = 2'b01; cmd_index_i = 5'd20; cmd_data_i = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) @(negedge clk_i);
        checkOutput("full_ready_held", 32'(cmd_ready_o), 32'd0);
        checkOutput("hold_rspv_a",     32'(rsp_valid_o), 32'd1);
        checkOutput("hold_idx_a",      32'(rsp_index_o), 32'd10);
        checkOutput("hold_data_a",     rsp_data_o,       32'h100);
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("hold_rspv_b",     32'(rsp_valid_o), 32'd1);
        checkOutput("hold_idx_b",      32'(rsp_index_o), 32'd10);
        checkOutput("hold_data_b",     rsp_data_o,       32'h100);
        expectRsp("drain0", 2'b01, 1'b1, 5'd10, 32'h100);
        checkOutput("ready_after_pop", 32'(cmd_ready_o), 32'd1);
        expectRsp("drain1", 2'b01, 1'b1, 5'd11, 32'h101);
        expectRsp("drain2", 2'b01, 1'b1, 5'd12, 32'h102);
        expectRsp("drain3", 2'b01, 1'b1, 5'd13, 32'h103);
        saw_rsp = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o) saw_rsp = 1;
            @(negedge clk_i);
        end
        checkOutput("no_fifth_rsp", 32'(saw_rsp), 32'd0);
        checkOutput("drain_busy",   32'(busy_o),  32'd0);

        // Back-to-back reads with rsp_ready tied high: 4-cycle spacing
        $display("[TB] throughput");
        rsp_ready_i = 1'b1;
        applyStimulus(2'b00, 5'd10, '0);
        applyStimulus(2'b00, 5'd11, '0);
        t_first = -1; t_second = -1;
        for (cycle = 0; cycle < 20; cycle++) begin
            if (rsp_valid_o) begin
                if (t_first < 0) t_first = cycle;
                else if (t_second < 0) t_second = cycle;
            end
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b0;
        checkOutput("b2b_spacing", 32'(t_second - t_first), 32'd4);

        // Reset during WAIT of a read with another command queued
        $display("[TB] reset mid-operation");
        cmd_valid_i = 1'b1; cmd_op_i = 2'b00; cmd_index_i = 5'd5;
        @(negedge clk_i);                                  // N+1
        cmd_op_i = 2'b01; cmd_index_i = 5'd7; cmd_data_i = 32'h77;
        @(negedge clk_i);                                  // N+2 (ISSUE)
        cmd_valid_i = 1'b0;
        checkOutput("mid_re_issue", 32'(read_enable_o), 32'd1);
        @(negedge clk_i);                                  // N+3 (WAIT)
        rst_i = 1'b0;
        #1;
        checkOutput("mid_strb", 32'({read_enable_o, write_enable_o, search_enable_o}), 32'd0);
        checkOutput("mid_rspv", 32'(rsp_valid_o), 32'd0);
        checkOutput("mid_busy", 32'(busy_o),      32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("post_rst_busy",  32'(busy_o),      32'd0);
        checkOutput("post_rst_ready", 32'(cmd_ready_o), 32'd1);
        s_wr = wr_strobes;
        saw_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid_o) saw_rsp = 1;
            @(negedge clk_i);
        end
        checkOutput("post_rst_no_rsp", 32'(saw_rsp), 32'd0);
        checkOutput("post_rst_no_wr",  32'(wr_strobes - s_wr), 32'd0);

        // Reset during ISSUE of a write: strobe drops at once
        cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_index_i = 5'd8; cmd_data_i = 32'h88;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("issue_we", 32'(write_enable_o), 32'd1);
        rst_i = 1'b0;
        #1;
        checkOutput("issue_we_rst", 32'(write_enable_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Reserved op: no strobe ever, zeroed response at N+3
        $display("[TB] reserved op");
        s_rd = rd_strobes; s_wr = wr_strobes; s_sr = sr_strobes;
        cmd_valid_i = 1'b1; cmd_op_i = 2'b11; cmd_index_i = 5'd7; cmd_data_i = 32'hAAAA5555;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);                       // N+3
        checkOutput("rsv_rspv_N3", 32'(rsp_valid_o), 32'd1);
        expectRsp("rsv", 2'b11, 1'b0, 5'd0, 32'd0);
        checkOutput("rsv_no_strobe",
                    32'((rd_strobes - s_rd) + (wr_strobes - s_wr) + (sr_strobes - s_sr)), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
